// File: rtl/hmmm_program_loader.sv
// -----------------------------------------------------------------------------
// hmmm_program_loader
//
// Sequences a program download into the hmmm core's RAM over the core's shared
// io bus. The host streams instruction words in over a valid/ready handshake.
// For each word the loader drives two phases on the io bus:
//   1. a pgrm_addr cycle, which loads the MAR with the RAM address;
//   2. a pgrm_data cycle, which writes the word into RAM through the MDR.
// The core is held in reset for the whole session. At the end of the session
// the loader releases the core and pulses done.
//
// State flow: IDLE -> WAIT -> ADDR -> DATA -> (WAIT | FINISH) -> IDLE
//
// Optional feature (compile-time macro HMMM_LOADER_CHECKSUM_EN):
//   defined   : checksum_o accumulates the sum (mod 2^DATA_W) of every word
//               written during DATA. It is cleared on start and holds after
//               the session ends.
//   undefined : checksum_o is tied to zero and no adder is built.
//
// Ports
//   clk_i          core clock; all state changes on its rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a load session (sampled only in IDLE)
//   word_valid_i   host word available
//   word_data_i    host instruction word
//   word_last_i    marks word_data_i as the final program word
//   word_ready_o   loader accepts a word this cycle
//   pgrm_addr_o    io bus carries a RAM address this cycle
//   pgrm_data_o    io bus carries a RAM data word this cycle
//   io_out_o       value driven onto the core io bus
//   io_oe_o        io_out_o is valid (pgrm_addr_o | pgrm_data_o)
//   core_rst_o     active-high hold-in-reset for the core
//   busy_o         session in progress
//   done_o         one-cycle pulse at session end
//   overflow_o     sticky: session ended on address wrap without word_last
//   word_count_o   number of words written in the current/last session
//   checksum_o     running word sum (see optional feature above)
// -----------------------------------------------------------------------------
module hmmm_program_loader #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DATA_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_data_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  output logic              pgrm_addr_o,
  output logic              pgrm_data_o,
  output logic [DATA_W-1:0] io_out_o,
  output logic              io_oe_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;

  // Output registers. Their next values are decoded from state_d, so every
  // output lines up with the state the FSM is entering.
  logic                ready_q, ready_d;
  logic                paddr_q, paddr_d;
  logic                pdata_q, pdata_d;
  logic [DATA_W-1:0]   io_q, io_d;
  logic                oe_q, oe_d;
  logic                crst_q, crst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_ok;
  logic                accept;
  logic                at_top;

  assign start_ok = (state_q == S_IDLE) && start_i;
  // ready_q is high throughout WAIT, so this is the plain valid & ready handshake.
  assign accept   = (state_q == S_WAIT) && word_valid_i && ready_q;
  assign at_top   = (addr_q == ADDR_MAX);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        // word_valid_i is ignored here. A word offered together with start
        // is picked up one cycle later, in WAIT.
        if (start_i) begin
          state_d = S_WAIT;
          addr_d  = BASE_ADDR;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (accept) begin
          word_d  = word_data_i;
          last_d  = word_last_i;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        count_d = count_q + CNT_ONE;
        addr_d  = addr_q + ADDR_ONE;   // wraps modulo 2^ADDR_W
        if (last_q || at_top) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
        // Ran out of address space before the host marked the last word.
        if (at_top && !last_q) begin
          ovf_d = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs, decoded from the state being entered.
    ready_d = (state_d == S_WAIT);
    paddr_d = (state_d == S_ADDR);
    pdata_d = (state_d == S_DATA);
    oe_d    = paddr_d | pdata_d;
    busy_d  = (state_d != S_IDLE);
    crst_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);

    io_d = '0;
    if (paddr_d) begin
      io_d = DATA_W'(addr_q);
    end else if (pdata_d) begin
      io_d = word_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      paddr_q <= 1'b0;
      pdata_q <= 1'b0;
      io_q    <= '0;
      oe_q    <= 1'b0;
      crst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum
  // ---------------------------------------------------------------------------
`ifdef HMMM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (state_q == S_DATA) begin
      csum_d = csum_q + word_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

  assign word_ready_o = ready_q;
  assign pgrm_addr_o  = paddr_q;
  assign pgrm_data_o  = pdata_q;
  assign io_out_o     = io_q;
  assign io_oe_o      = oe_q;
  assign core_rst_o   = crst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = count_q;

endmodule
